exibe_sequencia: RTL
====================

# exibe_sequencia

Sequence playback unit for the memory game: on a start pulse it reads the sync ROM from address 0 up to a latched limit and drives each stored 4-bit pattern onto the LEDs for a fixed on-time, followed by a blank gap. It is the output-side counterpart of the play datapath, which reads player keys and compares them against the same ROM. It sits between the top-level controller (`iniciar`/`pronto`) and `sync_rom_16x4`, which it addresses while the player side is idle.

## Interface
- `T_ACESO`, default 500: LED on-time per element, in clock cycles; must be ≥1.
- `T_APAGADO`, default 250: blank gap after each element, in cycles; must be ≥1.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state and outputs.
- `iniciar`  in  1  start request; sampled only in OCIOSO.
- `limite`  in  4  index of the last element to show; latched at start.
- `dado`  in  4  ROM `data_out`, valid one cycle after `endereco` is sampled.
- `endereco`  out  4  ROM address.
- `leds`  out  4  registered LED pattern; 0 when not lit.
- `ocupado`  out  1  high in every state except OCIOSO.
- `pronto`  out  1  one-cycle pulse when playback completes.
- `db_estado`  out  4  current state code, for debugging.

## Operation
- States and codes: OCIOSO=0, BUSCA=1, LEITURA=2, ACESO=3, APAGADO=4, PROXIMO=5, FIM=6.
- OCIOSO: `iniciar`=1 → BUSCA; `endereco`←0, limit register ←`limite`.
- BUSCA: the ROM samples `endereco` → LEITURA.
- LEITURA: `dado` is now valid → ACESO; `leds`←`dado`; timer←T_ACESO−1.
- ACESO: decrement the timer; at 0 → APAGADO; `leds`←0; timer←T_APAGADO−1.
- APAGADO: decrement the timer; at 0 → PROXIMO.
- PROXIMO: if `endereco` = latched limit → FIM; otherwise `endereco`+1 → BUSCA.
- FIM: `pronto`=1 for exactly this cycle → OCIOSO. `endereco` holds its last value until the next start.
- A ROM value of 0 still runs its full ACESO interval with `leds`=0; there is no early skip.
- `iniciar` outside OCIOSO is ignored; there is no restart mid-playback.
- Changes to `limite` after start have no effect.
- `endereco` never wraps: with limite=15, the sequence ends at address 15 and goes to FIM.

## Timing
- Reset values: state=OCIOSO, `endereco`=0, `leds`=0, `ocupado`=0, `pronto`=0, `db_estado`=0, timer=0, limit register=0.
- `reset` overrides everything, including mid-playback: on the next edge all values above are restored and no `pronto` is produced.
- Cycle numbering: n counts from the edge that samples `iniciar`=1 (state is OCIOSO before it).
- Per element: 1 (BUSCA) + 1 (LEITURA) + T_ACESO + T_APAGADO + 1 (PROXIMO) cycles.
- Cycles 1 and 2 are BUSCA and LEITURA; `leds` is first nonzero (if `dado`≠0) in cycle 3.
- `pronto` is high in cycle (L+1)·(T_ACESO+T_APAGADO+3)+1, where L is the latched limit; `ocupado` falls in the following cycle.
- `iniciar` held high through FIM starts a new playback immediately after returning to OCIOSO.

## Structure
- Shared package `jogo_pkg`: state code constants; ROM address/data width constant (4).
- Timer width: clog2(max(T_ACESO, T_APAGADO)).
- Natural sub-module: `temporizador_carga`, a loadable down-counter with a `zero` flag, instantiated once and shared by ACESO and APAGADO.
- FSM and the address register stay in the top module.

## Test plan
All scenarios use T_ACESO=3, T_APAGADO=2 (8 cycles per element) and a ROM preloaded with 1,2,4,8,…
- limite=2, pulse `iniciar` → `leds` = 1, 2, 4 in cycles 3–5, 11–13, 19–21; `leds`=0 in cycles 6–7; `pronto` only in cycle 25.
- limite=0 → a single element: `leds`=1 in cycles 3–5, `pronto` in cycle 9, `endereco` stays 0.
- limite=15 → 16 elements, `endereco` ends at 15 without wrapping, `pronto` in cycle 129.
- Toggle `limite` and pulse `iniciar` mid-playback → output identical to the unperturbed run.
- Assert `reset` in cycle 12 → next cycle all outputs are 0 and state=OCIOSO; no `pronto`; a new `iniciar` restarts from address 0.
- `iniciar` held high continuously → back-to-back playbacks, each `pronto` a single-cycle pulse.

Source files
------------

// File: rtl/jogo_pkg.sv
// Shared definitions for the memory-game datapath: state codes and widths.
package jogo_pkg;

  // ROM address and data width.
  localparam int unsigned LarguraRom = 4;

  // Playback FSM state codes (also driven out on db_estado).
  typedef enum logic [3:0] {
    StOcioso  = 4'd0,
    StBusca   = 4'd1,
    StLeitura = 4'd2,
    StAceso   = 4'd3,
    StApagado = 4'd4,
    StProximo = 4'd5,
    StFim     = 4'd6
  } estado_t;

  // Timer width that can hold the larger of the two reload values (T - 1).
  function automatic int unsigned largura_timer(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/exibe_sequencia_temporizador_carga.sv
// Loadable down-counter with a zero flag. It is shared by the LED on-time
// and blank-gap intervals.
module temporizador_carga #(
  parameter int unsigned Largura = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_carregar,
  input  logic [Largura-1:0] i_valor,
  input  logic               i_decrementar,
  output logic               o_zero
);

  logic [Largura-1:0] r_contagem;

  // Load has priority over decrement; the counter saturates at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_contagem <= '0;
    end else if (i_carregar) begin
      r_contagem <= i_valor;
    end else if (i_decrementar && (r_contagem != '0)) begin
      r_contagem <= r_contagem - Largura'(1);
    end
  end

  assign o_zero = (r_contagem == '0);

endmodule

// File: rtl/exibe_sequencia.sv
// Sequence playback. On a start request it reads the sync ROM from address 0
// up to a latched limit. Each pattern is shown on the LEDs for T_ACESO cycles,
// followed by a blank gap of T_APAGADO cycles.
module exibe_sequencia
  import jogo_pkg::*;
#(
  parameter int unsigned T_ACESO   = 500,
  parameter int unsigned T_APAGADO = 250
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  iniciar,
  input  logic [LarguraRom-1:0] limite,
  input  logic [LarguraRom-1:0] dado,
  output logic [LarguraRom-1:0] endereco,
  output logic [LarguraRom-1:0] leds,
  output logic                  ocupado,
  output logic                  pronto,
  output logic [3:0]            db_estado
);

  localparam int unsigned LarguraTimer = largura_timer(T_ACESO, T_APAGADO);
  localparam logic [LarguraTimer-1:0] CargaAceso   = LarguraTimer'(T_ACESO - 1);
  localparam logic [LarguraTimer-1:0] CargaApagado = LarguraTimer'(T_APAGADO - 1);

  estado_t                 r_estado;
  logic [LarguraRom-1:0]   r_endereco;
  logic [LarguraRom-1:0]   r_limite;
  logic [LarguraRom-1:0]   r_leds;
  logic                    r_ocupado;
  logic                    r_pronto;

  logic                    w_zero;
  logic                    w_carregar;
  logic                    w_decrementar;
  logic [LarguraTimer-1:0] w_valor;

  // Timer control: load on entry to each interval, count down while in it.
  always_comb begin
    w_carregar    = 1'b0;
    w_decrementar = 1'b0;
    w_valor       = CargaAceso;
    case (r_estado)
      StLeitura: begin
        w_carregar = 1'b1;
        w_valor    = CargaAceso;
      end
      StAceso: begin
        if (w_zero) begin
          w_carregar = 1'b1;
          w_valor    = CargaApagado;
        end else begin
          w_decrementar = 1'b1;
        end
      end
      StApagado: w_decrementar = !w_zero;
      default: ;
    endcase
  end

  temporizador_carga #(
    .Largura (LarguraTimer)
  ) u_temporizador (
    .clock         (clock),
    .reset         (reset),
    .i_carregar    (w_carregar),
    .i_valor       (w_valor),
    .i_decrementar (w_decrementar),
    .o_zero        (w_zero)
  );

  // Playback FSM with registered outputs; iniciar and limite only matter in StOcioso.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado   <= StOcioso;
      r_endereco <= '0;
      r_limite   <= '0;
      r_leds     <= '0;
      r_ocupado  <= 1'b0;
      r_pronto   <= 1'b0;
    end else begin
      r_pronto <= 1'b0;
      case (r_estado)
        StOcioso: begin
          if (iniciar) begin
            r_estado   <= StBusca;
            r_endereco <= '0;
            r_limite   <= limite;
            r_ocupado  <= 1'b1;
          end
        end
        // The ROM samples endereco on this edge.
        StBusca: r_estado <= StLeitura;
        StLeitura: begin
          r_estado <= StAceso;
          r_leds   <= dado;
        end
        StAceso: begin
          if (w_zero) begin
            r_estado <= StApagado;
            r_leds   <= '0;
          end
        end
        StApagado: begin
          if (w_zero) begin
            r_estado <= StProximo;
          end
        end
        // Compare before incrementing so address 15 never wraps.
        StProximo: begin
          if (r_endereco == r_limite) begin
            r_estado <= StFim;
            r_pronto <= 1'b1;
          end else begin
            r_endereco <= r_endereco + 1'b1;
            r_estado   <= StBusca;
          end
        end
        StFim: begin
          r_estado  <= StOcioso;
          r_ocupado <= 1'b0;
        end
        default: begin
          r_estado  <= StOcioso;
          r_ocupado <= 1'b0;
          r_leds    <= '0;
        end
      endcase
    end
  end

  assign endereco  = r_endereco;
  assign leds      = r_leds;
  assign ocupado   = r_ocupado;
  assign pronto    = r_pronto;
  assign db_estado = r_estado;

endmodule
